// File: rtl/rvc_fetch_pkg.sv
// Shared encodings and the fetch buffer entry type for the RV32EC fetch stage.
package rvc_fetch_pkg;

    localparam logic [15:0] C_EBREAK_ENC = 16'h9002;
    localparam logic [15:0] C_NOP_ENC    = 16'h0001;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, inst} pairs; flush beats push and pop.
module fetch_fifo
    import rvc_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pushing into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= entry;
        end
    end

endmodule

// File: rtl/rvc_fetch_stage.sv
// RV32EC fetch stage: PC register, ROM addressing, fetch buffer, redirect and c.ebreak halt.
module rvc_fetch_stage
    import rvc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [15:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFE;

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         halted_q;
    logic         halted_d;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         push;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
    fetch_entry_t last_q;

    assign address  = {1'b0, pc_q[31:1]};
    assign pop      = !fifo_empty && out_ready;
    assign push     = !halted_q && !redirect_valid && (!fifo_full || pop);
    assign wr_entry = '{pc: pc_q, inst: instruction};
    assign halted   = halted_q;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_target & PC_ALIGN_MASK;
            halted_d = 1'b0;
        end else if (push) begin
            pc_d = pc_q + 32'd2;
            if (instruction == C_EBREAK_ENC) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC & PC_ALIGN_MASK;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .entry (wr_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Shadow of the last presented head so the outputs hold steady while the buffer is empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= '{pc: 32'h0, inst: C_NOP_ENC};
        end else if (!fifo_empty) begin
            last_q <= head;
        end
    end

    assign out_valid       = !fifo_empty;
    assign out_instruction = fifo_empty ? last_q.inst : head.inst;
    assign out_pc          = fifo_empty ? last_q.pc   : head.pc;

endmodule

// File: tb/tb_rvc_fetch_stage.sv
// Directed bench for rvc_fetch_stage driven by a small behavioural ROM.
module tb_rvc_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        out_ready = 1'b0;
    logic        stub_ebreak = 1'b0;

    logic [31:0] address, w_address;
    logic [15:0] instruction, w_instruction;
    logic        out_valid, w_out_valid;
    logic [15:0] out_instruction, w_out_instruction;
    logic [31:0] out_pc, w_out_pc;
    logic        halted, w_halted;

    int asserts = 0;
    int fails   = 0;

    always #5 clock = ~clock;

    function automatic logic [15:0] rom(input logic [31:0] a, input logic stub);
        case (a)
            32'd0:   return 16'h0001;
            32'd1:   return 16'h4705;
            32'd2:   return 16'h4781;
            32'd3:   return 16'h97BA;
            32'd5:   return stub ? 16'h9002 : 16'h0792;
            default: return 16'h0792;
        endcase
    endfunction

    assign instruction   = rom(address, stub_ebreak);
    assign w_instruction = rom(w_address, 1'b0);

    rvc_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .address         (address),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .halted          (halted)
    );

    rvc_fetch_stage #(
        .RESET_PC   (32'hFFFF_FFFE),
        .FIFO_DEPTH (2)
    ) dut_wrap (
        .clock           (clock),
        .reset           (reset),
        .address         (w_address),
        .instruction     (w_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (w_out_valid),
        .out_ready       (out_ready),
        .out_instruction (w_out_instruction),
        .out_pc          (w_out_pc),
        .halted          (w_halted)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        out_ready      = ready;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        asserts++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %b want 0", out_valid); fails++;
        end
        asserts++;
        if (out_instruction !== 16'h0001) begin
            $display("FAIL reset_inst: got %h want 0001", out_instruction); fails++;
        end
        asserts++;
        if (out_pc !== 32'h0) begin
            $display("FAIL reset_pc: got %h want 00000000", out_pc); fails++;
        end
        asserts++;
        if (address !== 32'h0) begin
            $display("FAIL reset_addr: got %h want 00000000", address); fails++;
        end
        asserts++;
        if (halted !== 1'b0) begin
            $display("FAIL reset_halted: got %b want 0", halted); fails++;
        end
        asserts++;
        if (w_address !== 32'h7FFF_FFFF) begin
            $display("FAIL reset_wrap_addr: got %h want 7fffffff", w_address); fails++;
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_inst [8] = '{16'h0001, 16'h4705, 16'h4781, 16'h97BA,
                                      16'h0792, 16'h0792, 16'h0792, 16'h0792};
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            asserts++;
            if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'(2 * i), exp_inst[i]}) begin
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_instruction, 32'(2 * i), exp_inst[i]);
                fails++;
            end
            asserts++;
            if (address !== 32'(i + 1)) begin
                $display("FAIL stream_addr_%0d: got %h want %h", i, address, 32'(i + 1)); fails++;
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp_inst [5] = '{16'h0001, 16'h4705, 16'h4781, 16'h97BA, 16'h0792};
        do_reset(1'b0);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if ({out_valid, out_pc, out_instruction, address} !==
                {1'b1, 32'h0, 16'h0001, 32'h2}) begin
                $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h addr=%h want v=1 pc=0 inst=0001 addr=2",
                         i, out_valid, out_pc, out_instruction, address);
                fails++;
            end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            asserts++;
            if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'(2 * i), exp_inst[i]}) begin
                $display("FAIL stall_resume_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_instruction, 32'(2 * i), exp_inst[i]);
                fails++;
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h7;
        tick();
        redirect_valid = 1'b0;
        asserts++;
        if ({out_valid, address} !== {1'b0, 32'h3}) begin
            $display("FAIL redirect_flush: got v=%b addr=%h want v=0 addr=3", out_valid, address); fails++;
        end
        tick();
        asserts++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h6, 16'h97BA}) begin
            $display("FAIL redirect_first: got v=%b pc=%h inst=%h want v=1 pc=6 inst=97ba",
                     out_valid, out_pc, out_instruction);
            fails++;
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        tick();
        redirect_target = 32'h6;
        tick();
        redirect_valid = 1'b0;
        asserts++;
        if ({out_valid, address} !== {1'b0, 32'h3}) begin
            $display("FAIL redirect_b2b: got v=%b addr=%h want v=0 addr=3", out_valid, address); fails++;
        end
        tick();
        asserts++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h6, 16'h97BA}) begin
            $display("FAIL redirect_b2b_first: got v=%b pc=%h inst=%h want v=1 pc=6 inst=97ba",
                     out_valid, out_pc, out_instruction);
            fails++;
        end
    endtask

    task automatic test_ebreak();
        logic [15:0] exp_inst [6] = '{16'h0001, 16'h4705, 16'h4781, 16'h97BA, 16'h0792, 16'h9002};
        stub_ebreak = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            asserts++;
            if ({out_valid, out_pc, out_instruction, halted} !==
                {1'b1, 32'(2 * i), exp_inst[i], (i == 5)}) begin
                $display("FAIL ebreak_seq_%0d: got v=%b pc=%h inst=%h h=%b want v=1 pc=%h inst=%h h=%b",
                         i, out_valid, out_pc, out_instruction, halted, 32'(2 * i), exp_inst[i], (i == 5));
                fails++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            asserts++;
            if ({out_valid, halted, address} !== {1'b0, 1'b1, 32'h6}) begin
                $display("FAIL ebreak_halt_%0d: got v=%b h=%b addr=%h want v=0 h=1 addr=6",
                         i, out_valid, halted, address);
                fails++;
            end
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        asserts++;
        if ({out_valid, halted, address} !== {1'b0, 1'b0, 32'h0}) begin
            $display("FAIL ebreak_unhalt: got v=%b h=%b addr=%h want v=0 h=0 addr=0",
                     out_valid, halted, address);
            fails++;
        end
        tick();
        asserts++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h0, 16'h0001}) begin
            $display("FAIL ebreak_restart: got v=%b pc=%h inst=%h want v=1 pc=0 inst=0001",
                     out_valid, out_pc, out_instruction);
            fails++;
        end
        stub_ebreak = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if ({w_out_valid, w_out_pc} !== {1'b1, exp_pc[i]}) begin
                $display("FAIL wrap_%0d: got v=%b pc=%h want v=1 pc=%h", i, w_out_valid, w_out_pc, exp_pc[i]);
                fails++;
            end
        end
    endtask

    task automatic test_midreset();
        do_reset(1'b1);
        tick();
        tick();
        tick();
        asserts++;
        if ({out_valid, out_pc} !== {1'b1, 32'h4}) begin
            $display("FAIL midreset_pre: got v=%b pc=%h want v=1 pc=4", out_valid, out_pc); fails++;
        end
        reset = 1'b1;
        #1;
        asserts++;
        if ({out_valid, address, out_pc, out_instruction} !== {1'b0, 32'h0, 32'h0, 16'h0001}) begin
            $display("FAIL midreset_async: got v=%b addr=%h pc=%h inst=%h want v=0 addr=0 pc=0 inst=0001",
                     out_valid, address, out_pc, out_instruction);
            fails++;
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if ({out_valid, out_pc} !== {1'b1, 32'(2 * i)}) begin
                $display("FAIL midreset_restart_%0d: got v=%b pc=%h want v=1 pc=%h",
                         i, out_valid, out_pc, 32'(2 * i));
                fails++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ebreak();
        test_wrap();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

endmodule
